// File: rtl/hreg_access_ctrl.sv
// Sequencer/arbiter sharing one Hamming-protected shift register between write, transmit and read.
// Optional even-parity bit after each transmit frame: define HREG_TX_PARITY_EN.
module hreg_access_ctrl #(
    parameter int unsigned width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    input  logic [width-1:0] wr_data,
    output logic             wr_ready,
    input  logic             tx_valid,
    input  logic [width-1:0] tx_data,
    output logic             tx_ready,
    output logic             tx_bit,
    output logic             tx_bit_valid,
    output logic             tx_done,
    input  logic             rd_req,
    output logic             rd_gnt,
    output logic [width-1:0] rd_data,
    output logic             rd_valid,
    output logic             busy,
    output logic             reg_enable,
    output logic             reg_load,
    output logic [1:0]       reg_mode,
    output logic [width-1:0] reg_parallel_in,
    output logic             reg_serial_in,
    input  logic [width-1:0] reg_parallel_out,
    input  logic             reg_serial_out
);

    localparam int unsigned CntW = $clog2(width + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(width - 1);

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StRead,
        StTxLoad,
        StTxShift,
        StTxPar
    } state_t;

    state_t           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             rr_q, rr_d;
    logic [width-1:0] hold_q, hold_d;
    logic [width-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            rr_q       <= 1'b0;
            hold_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rr_q       <= rr_d;
            hold_q     <= hold_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        rr_d            = rr_q;
        hold_d          = hold_q;
        rd_data_d       = rd_data_q;
        rd_valid_d      = 1'b0;
        wr_ready        = 1'b0;
        tx_ready        = 1'b0;
        rd_gnt          = 1'b0;
        tx_bit          = 1'b0;
        tx_bit_valid    = 1'b0;
        tx_done         = 1'b0;
        reg_enable      = 1'b0;
        reg_load        = 1'b0;
        reg_mode        = 2'b11;
        reg_parallel_in = '0;

        unique case (state_q)
            StIdle: begin
                // Grants are suppressed while reset is held so requests then are ignored.
                if (rst) begin
                    if (rd_req) begin
                        rd_gnt  = 1'b1;
                        state_d = StRead;
                    end else if (wr_valid && (!tx_valid || !rr_q)) begin
                        wr_ready = 1'b1;
                        hold_d   = wr_data;
                        rr_d     = 1'b1;
                        state_d  = StWrite;
                    end else if (tx_valid) begin
                        tx_ready = 1'b1;
                        hold_d   = tx_data;
                        rr_d     = 1'b0;
                        state_d  = StTxLoad;
                    end
                end
            end
            StWrite: begin
                reg_enable      = 1'b1;
                reg_load        = 1'b1;
                reg_mode        = 2'b11;
                reg_parallel_in = hold_q;
                state_d         = StIdle;
            end
            StRead: begin
                rd_data_d  = reg_parallel_out;
                rd_valid_d = 1'b1;
                state_d    = StIdle;
            end
            StTxLoad: begin
                reg_enable      = 1'b1;
                reg_load        = 1'b1;
                reg_mode        = 2'b10;
                reg_parallel_in = hold_q;
                cnt_d           = '0;
                state_d         = StTxShift;
            end
            StTxShift: begin
                reg_enable   = 1'b1;
                reg_mode     = 2'b10;
                tx_bit       = reg_serial_out;
                tx_bit_valid = 1'b1;
                cnt_d        = cnt_q + CntW'(1);
                if (cnt_q == CntLast) begin
`ifdef HREG_TX_PARITY_EN
                    state_d = StTxPar;
`else
                    tx_done = 1'b1;
                    state_d = StIdle;
`endif
                end
            end
`ifdef HREG_TX_PARITY_EN
            StTxPar: begin
                // Register released here so its correction path resumes during the parity bit.
                reg_mode     = 2'b10;
                tx_bit       = ^hold_q;
                tx_bit_valid = 1'b1;
                tx_done      = 1'b1;
                state_d      = StIdle;
            end
`endif
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign rd_data       = rd_data_q;
    assign rd_valid      = rd_valid_q;
    assign busy          = (state_q != StIdle);
    assign reg_serial_in = 1'b0;

endmodule

// File: tb/tb_hreg_access_ctrl.sv
// Bench for hreg_access_ctrl: behavioural Hamming register model, scoreboard queues, vector table.
module tb_hreg_access_ctrl;

    localparam int unsigned W = 8;
`ifdef HREG_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int OpWr = 1;
    localparam int OpTx = 2;
    localparam int OpRd = 3;

    logic         clk, rst;
    logic         wr_valid, wr_ready, tx_valid, tx_ready, tx_bit, tx_bit_valid, tx_done;
    logic [W-1:0] wr_data, tx_data, rd_data, reg_parallel_in, reg_parallel_out;
    logic         rd_req, rd_gnt, rd_valid, busy, reg_enable, reg_load, reg_serial_in;
    logic         reg_serial_out;
    logic [1:0]   reg_mode;

    hreg_access_ctrl #(.width(W)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .tx_bit(tx_bit), .tx_bit_valid(tx_bit_valid), .tx_done(tx_done),
        .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_data(rd_data), .rd_valid(rd_valid),
        .busy(busy), .reg_enable(reg_enable), .reg_load(reg_load), .reg_mode(reg_mode),
        .reg_parallel_in(reg_parallel_in), .reg_serial_in(reg_serial_in),
        .reg_parallel_out(reg_parallel_out), .reg_serial_out(reg_serial_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- Hamming(7,4)-per-nibble register model ----------------
    logic [W-1:0]         mem = '0;
    logic [3*(W/4)-1:0]   par = '0;
    logic                 flip_req = 1'b0;
    logic [W-1:0]         corr;

    function automatic logic [2:0] enc(input logic [3:0] d);
        return {d[1] ^ d[2] ^ d[3], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
    endfunction

    function automatic logic [3*(W/4)-1:0] enc_all(input logic [W-1:0] m);
        logic [3*(W/4)-1:0] p;
        p = '0;
        for (int b = 0; b < W / 4; b++) p[3*b+:3] = enc(m[4*b+:4]);
        return p;
    endfunction

    function automatic logic [W-1:0] fix(input logic [W-1:0] m, input logic [3*(W/4)-1:0] p);
        logic [W-1:0] r;
        logic [2:0]   s;
        r = m;
        for (int b = 0; b < W / 4; b++) begin
            s = enc(m[4*b+:4]) ^ p[3*b+:3];
            case (s)
                3'd3: r[4*b]   = ~r[4*b];
                3'd5: r[4*b+1] = ~r[4*b+1];
                3'd6: r[4*b+2] = ~r[4*b+2];
                3'd7: r[4*b+3] = ~r[4*b+3];
                default: ;
            endcase
        end
        return r;
    endfunction

    assign corr             = fix(mem, par);
    assign reg_parallel_out = corr;
    assign reg_serial_out   = corr[0];

    initial forever begin
        @(posedge clk);
        if (flip_req) begin
            mem <= mem ^ W'(32);
        end else if (reg_enable && reg_load) begin
            mem <= reg_parallel_in;
            par <= enc_all(reg_parallel_in);
        end else if (reg_enable && reg_mode == 2'b10) begin
            mem <= {reg_serial_in, corr[W-1:1]};
            par <= enc_all({reg_serial_in, corr[W-1:1]});
        end else if (!reg_enable) begin
            mem <= corr;
            par <= enc_all(corr);
        end
    end

    // ---------------- checking infrastructure ----------------
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int tx_done_cnt = 0;
    int tx_pops = 0;
    logic [W-1:0] shadow = '0;

    typedef struct {logic b; int cyc; logic last;} tx_exp_t;
    typedef struct {logic [W-1:0] d; int cyc;} rd_exp_t;
    typedef struct {int op; logic [W-1:0] data; logic [W-1:0] exp;} vec_t;
    tx_exp_t txq[$];
    rd_exp_t rdq[$];
    int      grants[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Accepted handshakes produce the expected future output stream.
    initial forever begin
        @(posedge clk);
        if (rst === 1'b1) begin
            int n;
            n = int'(wr_valid && wr_ready) + int'(tx_valid && tx_ready) + int'(rd_req && rd_gnt);
            if (n != 0) chk("one_grant", n, 1);
            if (wr_valid && wr_ready) begin
                shadow = wr_data;
                grants.push_back(OpWr);
            end
            if (tx_valid && tx_ready) begin
                for (int i = 0; i < W; i++)
                    txq.push_back('{b: tx_data[i], cyc: cyc + 2 + i,
                                    last: (PAR == 0) && (i == W - 1)});
                if (PAR != 0) txq.push_back('{b: ^tx_data, cyc: cyc + 2 + W, last: 1'b1});
                shadow = '0;
                grants.push_back(OpTx);
            end
            if (rd_req && rd_gnt) begin
                rdq.push_back('{d: shadow, cyc: cyc + 2});
                grants.push_back(OpRd);
            end
        end
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        #1;
        if (rst === 1'b1) begin
            if (tx_done) tx_done_cnt++;
            if (tx_bit_valid) begin
                chk("tx_bit_expected", int'(txq.size() != 0), 1);
                if (txq.size() != 0) begin
                    tx_exp_t e;
                    e = txq.pop_front();
                    tx_pops++;
                    chk("tx_bit", tx_bit, e.b);
                    chk("tx_bit_cycle", cyc, e.cyc);
                    chk("tx_done", tx_done, e.last);
                end
            end else if (tx_done) begin
                chk("tx_done_without_bit", tx_done, 0);
            end
            if (rd_valid) begin
                chk("rd_expected", int'(rdq.size() != 0), 1);
                if (rdq.size() != 0) begin
                    rd_exp_t r;
                    r = rdq.pop_front();
                    chk("rd_data", rd_data, r.d);
                    chk("rd_cycle", cyc, r.cyc);
                end
            end
            if (busy && (wr_valid || tx_valid || rd_req))
                chk("no_grant_busy", {wr_ready, tx_ready, rd_gnt}, 0);
        end
    end

    function automatic logic cur_ready(input int op);
        case (op)
            OpWr:    return wr_ready;
            OpTx:    return tx_ready;
            default: return rd_gnt;
        endcase
    endfunction

    task automatic run_op(input int op, input logic [W-1:0] data);
        int   n;
        logic rdy;
        @(negedge clk);
        case (op)
            OpWr:    begin wr_valid = 1'b1; wr_data = data; end
            OpTx:    begin tx_valid = 1'b1; tx_data = data; end
            default: rd_req = 1'b1;
        endcase
        n = 0;
        #1 rdy = cur_ready(op);
        while (!rdy && n < 200) begin
            @(negedge clk);
            #1 rdy = cur_ready(op);
            n++;
        end
        chk("grant_wait", rdy, 1);
        @(negedge clk);
        wr_valid = 1'b0;
        tx_valid = 1'b0;
        rd_req   = 1'b0;
    endtask

    task automatic wait_idle();
        int   n;
        logic done;
        n = 0;
        done = 1'b0;
        while (!done && n < 100) begin
            @(negedge clk);
            #2 done = !busy && txq.size() == 0 && rdq.size() == 0;
            n++;
        end
        chk("idle_wait", done, 1);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_busy", busy, 0);
        chk("rst_grants", {wr_ready, tx_ready, rd_gnt}, 0);
        chk("rst_tx", {tx_bit, tx_bit_valid, tx_done}, 0);
        chk("rst_rd", {rd_valid, rd_data}, 0);
        chk("rst_reg_ctl", {reg_enable, reg_load, reg_serial_in}, 0);
        chk("rst_reg_mode", reg_mode, 2'b11);
        chk("rst_reg_pin", reg_parallel_in, 0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        wr_valid = 1'b0;
        tx_valid = 1'b0;
        rd_req   = 1'b0;
        repeat (2) @(negedge clk);
        #1 chk_reset_outputs();
        txq.delete();
        rdq.delete();
        @(negedge clk);
        rst = 1'b1;
    endtask

    // A request raised while the block serves another op must wait, then use its original word.
    task automatic backpressure(input int op, input logic [W-1:0] d, input logic [W-1:0] txd);
        int n;
        run_op(op, d);
        #1 chk("bp_busy", busy, 1);
        tx_valid = 1'b1;
        tx_data  = txd;
        #1 chk("bp_tx_ready_low", tx_ready, 0);
        n = 0;
        while (!tx_ready && n < 20) begin
            @(negedge clk);
            #1 n++;
        end
        chk("bp_tx_served", tx_ready, 1);
        @(negedge clk);
        tx_valid = 1'b0;
        wait_idle();
    endtask

    vec_t vecs[13];
    int   exp_gr[5];

    initial begin
        int n;
        int done_before;
        int pops_before;

        rst = 1'b0;
        wr_valid = 1'b0; tx_valid = 1'b0; rd_req = 1'b0;
        wr_data = '0; tx_data = '0;

        vecs[0]  = '{OpWr, 8'hA5, 8'h00};
        vecs[1]  = '{OpRd, 8'h00, 8'hA5};
        vecs[2]  = '{OpTx, 8'h3C, 8'h00};
        vecs[3]  = '{OpRd, 8'h00, 8'h00};
        vecs[4]  = '{OpWr, 8'hFF, 8'h00};
        vecs[5]  = '{OpRd, 8'h00, 8'hFF};
        vecs[6]  = '{OpTx, 8'h01, 8'h00};
        vecs[7]  = '{OpTx, 8'h80, 8'h00};
        vecs[8]  = '{OpRd, 8'h00, 8'h00};
        vecs[9]  = '{OpWr, 8'h5A, 8'h00};
        vecs[10] = '{OpRd, 8'h00, 8'h5A};
        vecs[11] = '{OpWr, 8'h00, 8'h00};
        vecs[12] = '{OpRd, 8'h00, 8'h00};

        apply_reset();

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].op, vecs[i].data);
            wait_idle();
            if (vecs[i].op == OpRd) chk("tbl_rd_data", rd_data, vecs[i].exp);
        end

        // Single-bit upset in the stored word is corrected on read-back.
        run_op(OpWr, 8'hF0);
        wait_idle();
        @(negedge clk) flip_req = 1'b1;
        @(negedge clk) flip_req = 1'b0;
        run_op(OpRd, '0);
        wait_idle();
        chk("corr_rd_data", rd_data, 8'hF0);

        // Round-robin between held WR and TX, then RD pre-empts both.
        apply_reset();
        grants.delete();
        @(negedge clk);
        wr_data = 8'h11; tx_data = 8'h81;
        wr_valid = 1'b1; tx_valid = 1'b1;
        n = 0;
        while (grants.size() < 4 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("rr_grant_count", grants.size(), 4);
        rd_req = 1'b1;
        n = 0;
        while (grants.size() < 5 && n < 60) begin
            @(negedge clk);
            n++;
        end
        rd_req = 1'b0; wr_valid = 1'b0; tx_valid = 1'b0;
        exp_gr = '{OpWr, OpTx, OpWr, OpTx, OpRd};
        for (int i = 0; i < 5; i++)
            chk($sformatf("rr_grant_%0d", i), (grants.size() > i) ? grants[i] : 0, exp_gr[i]);
        wait_idle();

        // Reset in the middle of a transmit frame.
        done_before = tx_done_cnt;
        pops_before = tx_pops;
        run_op(OpTx, 8'hA5);
        n = 0;
        while (tx_pops < pops_before + 3 && n < 50) begin
            @(negedge clk);
            #2 n++;
        end
        chk("abort_bits_seen", tx_pops - pops_before, 3);
        rst = 1'b0;
        #1 chk_reset_outputs();
        chk("abort_bits_left", txq.size(), W - 3 + PAR);
        txq.delete();
        repeat (2) @(negedge clk);
        #1 chk("abort_busy", busy, 0);
        chk("abort_no_done", tx_done_cnt, done_before);
        @(negedge clk) rst = 1'b1;
        run_op(OpTx, 8'h01);
        wait_idle();

        // Backpressure during WRITE and during READ.
        backpressure(OpWr, 8'h3C, 8'h96);
        backpressure(OpRd, 8'h00, 8'h6B);
        chk("bp_last_read", rd_data, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
